// File: rtl/rgb_ycbcr_pipe_if.sv
// Pixel bus between the VGA controller, the RGB->YCbCr converter and the capture logic.
// The converter takes the slave view: it consumes the RGB side and drives the YCbCr side.
interface rgb_ycbcr_pipe_if #(
    parameter int LINE_CNT_W = 16
);
    logic                  iCe;
    logic [7:0]            iR;
    logic [7:0]            iG;
    logic [7:0]            iB;
    logic                  iHSync;
    logic                  iVSync;
    logic                  iLineValid;
    logic                  iFrameValid;

    logic [7:0]            oY;
    logic [7:0]            oCb;
    logic [7:0]            oCr;
    logic                  oHSync;
    logic                  oVSync;
    logic                  oLineValid;
    logic                  oFrameValid;
    logic                  oFrameDone;
    logic [LINE_CNT_W-1:0] oLineCnt;

    modport master (
        output iCe, iR, iG, iB, iHSync, iVSync, iLineValid, iFrameValid,
        input  oY, oCb, oCr, oHSync, oVSync, oLineValid, oFrameValid, oFrameDone, oLineCnt
    );

    modport slave (
        input  iCe, iR, iG, iB, iHSync, iVSync, iLineValid, iFrameValid,
        output oY, oCb, oCr, oHSync, oVSync, oLineValid, oFrameValid, oFrameDone, oLineCnt
    );
endinterface

// File: rtl/rgb_ycbcr_pipe.sv
// Three-stage BT.601 full-range RGB to YCbCr converter with delay-matched VGA timing
// strobes, plus an active-line counter that reports lines per frame to the capture logic.
module rgb_ycbcr_pipe #(
    parameter logic SYNC_IDLE  = 1'b1,
    parameter int   LINE_CNT_W = 16
) (
    input  logic           iClk,
    input  logic           iRst,
    rgb_ycbcr_pipe_if.slave bus
);

    // Stage-1 products (coefficients scaled by 256, negative ones stored already negated)
    logic signed [17:0] pYr, pYg, pYb;
    logic signed [17:0] pCbR, pCbG, pCbB;
    logic signed [17:0] pCrR, pCrG, pCrB;

    // Stage-2 sums
    logic signed [17:0] sumY, sumCb, sumCr;

    // Stage-3 registered outputs
    logic [7:0] yReg, cbReg, crReg;

    // Strobe shift registers: bit 0 = stage 1, bit 2 = stage 3 (the outputs)
    logic [2:0] hsSr, vsSr, lvSr, fvSr;

    // Line counting state
    logic [LINE_CNT_W-1:0] lineCntInt;
    logic [LINE_CNT_W-1:0] lineCntReg;
    logic                  frameDoneReg;

    // Zero-extended pixel components for signed multiplication
    logic signed [17:0] rExt, gExt, bExt;
    assign rExt = $signed({10'd0, bus.iR});
    assign gExt = $signed({10'd0, bus.iG});
    assign bExt = $signed({10'd0, bus.iB});

    // Stage-3 offset/rounding and arithmetic shift back to 8-bit range
    logic signed [17:0] yShift, cbShift, crShift;
    assign yShift  = (sumY  + 18'sd128)   >>> 8;
    assign cbShift = (sumCb + 18'sd32896) >>> 8;
    assign crShift = (sumCr + 18'sd32896) >>> 8;

    // Edge detection on the delayed strobes: bit 1 is what bit 2 becomes on the next enabled edge
    logic lvRise, fvFall;
    assign lvRise = lvSr[1] & ~lvSr[2];
    assign fvFall = fvSr[2] & ~fvSr[1];

    function automatic logic [7:0] clampByte(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    // Stage 1: register the nine coefficient products
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pYr  <= '0; pYg  <= '0; pYb  <= '0;
            pCbR <= '0; pCbG <= '0; pCbB <= '0;
            pCrR <= '0; pCrG <= '0; pCrB <= '0;
        end else if (bus.iCe) begin
            pYr  <=  18'sd77  * rExt;
            pYg  <=  18'sd150 * gExt;
            pYb  <=  18'sd29  * bExt;
            pCbR <= -18'sd43  * rExt;
            pCbG <= -18'sd85  * gExt;
            pCbB <=  18'sd128 * bExt;
            pCrR <=  18'sd128 * rExt;
            pCrG <= -18'sd107 * gExt;
            pCrB <= -18'sd21  * bExt;
        end
    end

    // Stage 2: register the three component sums
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sumY  <= '0;
            sumCb <= '0;
            sumCr <= '0;
        end else if (bus.iCe) begin
            sumY  <= pYr  + pYg  + pYb;
            sumCb <= pCbR + pCbG + pCbB;
            sumCr <= pCrR + pCrG + pCrB;
        end
    end

    // Stage 3: clamp and register outputs, forcing black whenever the pixel is outside the active area
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            yReg  <= 8'd0;
            cbReg <= 8'd128;
            crReg <= 8'd128;
        end else if (bus.iCe) begin
            if (lvSr[1] & fvSr[1]) begin
                yReg  <= clampByte(yShift);
                cbReg <= clampByte(cbShift);
                crReg <= clampByte(crShift);
            end else begin
                yReg  <= 8'd0;
                cbReg <= 8'd128;
                crReg <= 8'd128;
            end
        end
    end

    // Strobe delay line matching the three arithmetic stages; syncs idle high because VGA sync is active-low
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hsSr <= {3{SYNC_IDLE}};
            vsSr <= {3{SYNC_IDLE}};
            lvSr <= '0;
            fvSr <= '0;
        end else if (bus.iCe) begin
            hsSr <= {hsSr[1:0], bus.iHSync};
            vsSr <= {vsSr[1:0], bus.iVSync};
            lvSr <= {lvSr[1:0], bus.iLineValid};
            fvSr <= {fvSr[1:0], bus.iFrameValid};
        end
    end

    // Active-line counter: a frame end wins over a coincident line start, and the count saturates
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            lineCntInt   <= '0;
            lineCntReg   <= '0;
            frameDoneReg <= 1'b0;
        end else if (bus.iCe) begin
            frameDoneReg <= fvFall;
            if (fvFall) begin
                lineCntReg <= lineCntInt;
                lineCntInt <= '0;
            end else if (lvRise && fvSr[1] && (lineCntInt != '1)) begin
                lineCntInt <= lineCntInt + 1'b1;
            end
        end
    end

    assign bus.oY          = yReg;
    assign bus.oCb         = cbReg;
    assign bus.oCr         = crReg;
    assign bus.oHSync      = hsSr[2];
    assign bus.oVSync      = vsSr[2];
    assign bus.oLineValid  = lvSr[2];
    assign bus.oFrameValid = fvSr[2];
    assign bus.oFrameDone  = frameDoneReg & bus.iCe;
    assign bus.oLineCnt    = lineCntReg;

endmodule

// File: tb/tb_rgb_ycbcr_pipe.sv
// Scoreboard bench for rgb_ycbcr_pipe: expected pixels/strobes are queued as stimulus is
// applied and compared when they emerge; a small frame model predicts oFrameDone/oLineCnt.
`timescale 1ns/1ps
module tb_rgb_ycbcr_pipe;

    localparam int LCW  = 3;
    localparam int MAXC = 7;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       hs;
        logic       vs;
        logic       lv;
        logic       fv;
    } outRec_t;

    localparam outRec_t IDLE_REC = '{y: 8'd0, cb: 8'd128, cr: 8'd128, hs: 1'b1, vs: 1'b1, lv: 1'b0, fv: 1'b0};

    logic iClk = 1'b0;
    logic iRst;

    rgb_ycbcr_pipe_if #(.LINE_CNT_W(LCW)) bus ();

    rgb_ycbcr_pipe #(.SYNC_IDLE(1'b1), .LINE_CNT_W(LCW)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .bus (bus)
    );

    always #5 iClk = ~iClk;

    outRec_t expQ[$];
    outRec_t lastExp;
    int      testsRun      = 0;
    int      testsFailed   = 0;
    int      frameDonePulses = 0;
    int      modelCnt      = 0;
    int      modelLatched  = 0;
    logic    prevLv        = 1'b0;
    logic    prevFv        = 1'b0;

    function automatic int clampTb(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference conversion written straight from the BT.601 full-range integer formulas
    function automatic outRec_t expectedOut(input int r, input int g, input int b,
                                            input logic hs, input logic vs,
                                            input logic lv, input logic fv);
        outRec_t rec;
        rec.hs = hs;
        rec.vs = vs;
        rec.lv = lv;
        rec.fv = fv;
        if (lv && fv) begin
            rec.y  = 8'(clampTb((77 * r + 150 * g + 29 * b + 128) >>> 8));
            rec.cb = 8'(clampTb((-43 * r - 85 * g + 128 * b + 32768 + 128) >>> 8));
            rec.cr = 8'(clampTb((128 * r - 107 * g - 21 * b + 32768 + 128) >>> 8));
        end else begin
            rec.y  = 8'd0;
            rec.cb = 8'd128;
            rec.cr = 8'd128;
        end
        return rec;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".y"},    bus.oY, 0);
        checkOutput({tag, ".cb"},   bus.oCb, 128);
        checkOutput({tag, ".cr"},   bus.oCr, 128);
        checkOutput({tag, ".hs"},   bus.oHSync, 1);
        checkOutput({tag, ".vs"},   bus.oVSync, 1);
        checkOutput({tag, ".lv"},   bus.oLineValid, 0);
        checkOutput({tag, ".fv"},   bus.oFrameValid, 0);
        checkOutput({tag, ".done"}, bus.oFrameDone, 0);
        checkOutput({tag, ".cnt"},  bus.oLineCnt, 0);
    endtask

    task automatic resetModel();
        expQ.delete();
        expQ.push_back(IDLE_REC);
        expQ.push_back(IDLE_REC);
        lastExp      = IDLE_REC;
        prevLv       = 1'b0;
        prevFv       = 1'b0;
        modelCnt     = 0;
        modelLatched = 0;
    endtask

    // Drive one cycle of inputs, wait an edge, then check whatever the pipeline should now present
    task automatic applyStimulus(input int r, input int g, input int b,
                                 input logic hs, input logic vs,
                                 input logic lv, input logic fv, input logic ce);
        outRec_t e;
        logic    expDone;
        bus.iR          = 8'(r);
        bus.iG          = 8'(g);
        bus.iB          = 8'(b);
        bus.iHSync      = hs;
        bus.iVSync      = vs;
        bus.iLineValid  = lv;
        bus.iFrameValid = fv;
        bus.iCe         = ce;
        if (ce) expQ.push_back(expectedOut(r, g, b, hs, vs, lv, fv));
        @(posedge iClk);
        #1;
        if (ce) begin
            e = expQ.pop_front();
            expDone = prevFv & ~e.fv;
            if (expDone) begin
                modelLatched = modelCnt;
                modelCnt     = 0;
            end else if (e.lv && !prevLv && e.fv && modelCnt != MAXC) begin
                modelCnt++;
            end
            prevLv = e.lv;
            prevFv = e.fv;
            lastExp = e;
            if (bus.oFrameDone === 1'b1) frameDonePulses++;
            checkOutput("y",    bus.oY, e.y);
            checkOutput("cb",   bus.oCb, e.cb);
            checkOutput("cr",   bus.oCr, e.cr);
            checkOutput("hs",   bus.oHSync, e.hs);
            checkOutput("vs",   bus.oVSync, e.vs);
            checkOutput("lv",   bus.oLineValid, e.lv);
            checkOutput("fv",   bus.oFrameValid, e.fv);
            checkOutput("done", bus.oFrameDone, expDone);
            checkOutput("cnt",  bus.oLineCnt, modelLatched);
        end else begin
            checkOutput("stall.y",    bus.oY, lastExp.y);
            checkOutput("stall.cb",   bus.oCb, lastExp.cb);
            checkOutput("stall.cr",   bus.oCr, lastExp.cr);
            checkOutput("stall.hs",   bus.oHSync, lastExp.hs);
            checkOutput("stall.vs",   bus.oVSync, lastExp.vs);
            checkOutput("stall.lv",   bus.oLineValid, lastExp.lv);
            checkOutput("stall.fv",   bus.oFrameValid, lastExp.fv);
            checkOutput("stall.done", bus.oFrameDone, 0);
            checkOutput("stall.cnt",  bus.oLineCnt, modelLatched);
        end
    endtask

    task automatic stallCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic randomPixel(input logic lv, input logic fv);
        applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                      lv, 1'b1, lv, fv, 1'b1);
    endtask

    // One frame of nLines lines; optional stalls mid-line and while the frame-done pulse is showing
    task automatic runFrame(input int nLines, input int expCnt, input bit withStalls);
        frameDonePulses = 0;
        randomPixel(1'b0, 1'b1);
        randomPixel(1'b0, 1'b1);
        for (int l = 0; l < nLines; l++) begin
            for (int p = 0; p < 3; p++) begin
                randomPixel(1'b1, 1'b1);
                if (withStalls && l == 1 && p == 0) stallCycles(4);
            end
            randomPixel(1'b0, 1'b1);
            randomPixel(1'b0, 1'b1);
        end
        for (int t = 0; t < 6; t++) begin
            randomPixel(1'b0, 1'b0);
            if (withStalls && t == 2) stallCycles(4);
        end
        checkOutput("frameDoneOnce", frameDonePulses, 1);
        checkOutput("frameLineCnt", bus.oLineCnt, expCnt);
    endtask

    localparam logic [15:0] HS_PAT = 16'b1110_0111_1111_0011;
    localparam logic [15:0] VS_PAT = 16'b1111_1100_0011_1111;
    localparam logic [15:0] LV_PAT = 16'b0110_1110_0101_1100;

    initial begin
        logic [15:0] hsPat;
        logic [15:0] vsPat;
        logic [15:0] lvPat;
        hsPat = HS_PAT;
        vsPat = VS_PAT;
        lvPat = LV_PAT;

        iRst = 1'b1;
        bus.iCe = 1'b1;
        bus.iR = '0; bus.iG = '0; bus.iB = '0;
        bus.iHSync = 1'b1; bus.iVSync = 1'b1;
        bus.iLineValid = 1'b0; bus.iFrameValid = 1'b0;
        #1;
        checkResetState("reset");
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        resetModel();

        // Single held pixel: black for two cycles, converted value on the third
        applyStimulus(123, 45, 68, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(123, 45, 68, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("preY", bus.oY, 0);
        applyStimulus(123, 45, 68, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("firstY",  bus.oY, 71);
        checkOutput("firstCb", bus.oCb, 126);
        checkOutput("firstCr", bus.oCr, 165);

        // Back-to-back colour sweep including clamp cases
        applyStimulus(0,   0,   255, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(255, 0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(255, 255, 255, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("sweepBlueY",  bus.oY, 29);
        checkOutput("sweepBlueCb", bus.oCb, 255);
        checkOutput("sweepBlueCr", bus.oCr, 107);
        applyStimulus(128, 128, 128, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("sweepRedY",  bus.oY, 77);
        checkOutput("sweepRedCb", bus.oCb, 85);
        checkOutput("sweepRedCr", bus.oCr, 255);
        randomPixel(1'b1, 1'b1);
        checkOutput("sweepWhiteY", bus.oY, 255);
        randomPixel(1'b1, 1'b1);
        checkOutput("sweepGrayY", bus.oY, 128);

        // Strobe pattern with random data; blanking follows delayed LineValid
        for (int i = 0; i < 16; i++)
            applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                          hsPat[i], vsPat[i], lvPat[i], 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) randomPixel(1'b0, 1'b0);

        // Frame accounting, saturation and clock-enable stalls
        runFrame(5, 5, 1'b0);
        runFrame(2, 2, 1'b0);
        runFrame(9, MAXC, 1'b0);
        runFrame(4, 4, 1'b1);

        // Asynchronous reset between clock edges in the middle of a frame
        for (int i = 0; i < 6; i++) randomPixel(i[1], 1'b1);
        #2;
        iRst = 1'b1;
        #1;
        checkResetState("asyncReset");
        #2;
        iRst = 1'b0;
        resetModel();
        runFrame(3, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
